exu_div: RTL

//  Iterative radix-2 restoring divider in the EXU, directly downstream of IDU1.

---
 rtl/exu_div_pkg.sv | 49 ++++
 rtl/exu_div_step.sv | 23 ++
 rtl/exu_div.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/exu_div_pkg.sv
// Shared types and sizing for the EXU iterative divider.
// The early-out feature is controlled by the EXU_DIV_EARLY_OUT_EN macro.
package exu_div_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic              div;
        logic              rem;
        logic              unsign;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rd_addr;
        logic [TAG_W-1:0]  instr_tag;
        logic              legal;
        logic              nop;
    } idu1_out_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   divisor;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   quo;
        logic              q_neg;
        logic              r_neg;
        logic              div_zero;
        logic              rem_sel;
        logic [4:0]        rd;
        logic [TAG_W-1:0]  tag;
    } div_dp_t;

    function automatic int div_cycles(input int unroll);
        return XLEN / unroll;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(
        input logic [XLEN-1:0] v,
        input logic            neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/exu_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
// A borrow out of the widened difference means the trial went negative.
module exu_div_step
    import exu_div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
    end

endmodule

// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define EXU_DIV_EARLY_OUT_EN to skip CALC for trivial operand pairs.
module exu_div
    import exu_div_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  idu1_out_t         idu1_out,
    input  logic              pipe_flush,
    output logic              exu_div_busy,
    output logic [XLEN-1:0]   div_wb_data,
    output logic [4:0]        div_wb_rd_addr,
    output logic [TAG_W-1:0]  div_wb_instr_tag,
    output logic              div_wb_rd_wr_en
);

    localparam int DIV_CYCLES = div_cycles(UNROLL);
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("exu_div: UNROLL must be 1, 2 or 4");
    end

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    div_dp_t           dp_q, dp_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic              wb_en_q, wb_en_d;

    logic              s1, s2;
    logic [XLEN-1:0]   a1, a2;
    logic              acc_req, accept;
    logic [XLEN-1:0]   q_fix, r_fix;

    logic [XLEN-1:0]   rem_c [UNROLL+1];
    logic [XLEN-1:0]   quo_c [UNROLL+1];

    assign s1      = ~idu1_out.unsign & idu1_out.rs1_data[XLEN-1];
    assign s2      = ~idu1_out.unsign & idu1_out.rs2_data[XLEN-1];
    assign a1      = abs_val(idu1_out.rs1_data, s1);
    assign a2      = abs_val(idu1_out.rs2_data, s2);
    assign acc_req = idu1_out.div & idu1_out.legal & ~idu1_out.nop;
    assign accept  = acc_req & ~pipe_flush & (state_q == DIV_IDLE);

    assign rem_c[0] = dp_q.rem;
    assign quo_c[0] = dp_q.quo;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        exu_div_step u_step (
            .rem_i     (rem_c[g]),
            .quo_i     (quo_c[g]),
            .divisor_i (dp_q.divisor),
            .rem_o     (rem_c[g+1]),
            .quo_o     (quo_c[g+1])
        );
    end

    // The raw iteration leaves rem = |rs1| for a zero divisor; only q needs forcing.
    assign q_fix = dp_q.div_zero ? '1 : (dp_q.q_neg ? -dp_q.quo : dp_q.quo);
    assign r_fix = dp_q.r_neg ? -dp_q.rem : dp_q.rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dp_d      = dp_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_tag_d  = wb_tag_q;
        wb_en_d   = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    dp_d.divisor  = a2;
                    dp_d.rem      = '0;
                    dp_d.quo      = a1;
                    dp_d.q_neg    = s1 ^ s2;
                    dp_d.r_neg    = s1;
                    dp_d.div_zero = (a2 == '0);
                    dp_d.rem_sel  = idu1_out.rem;
                    dp_d.rd       = idu1_out.rd_addr;
                    dp_d.tag      = idu1_out.instr_tag;
                    state_d       = DIV_CALC;
                    cnt_d         = CNT_W'(DIV_CYCLES);
`ifdef EXU_DIV_EARLY_OUT_EN
                    // Preload the unsigned result the full iteration would reach.
                    if (a2 == '0) begin
                        dp_d.quo = '1;
                        dp_d.rem = a1;
                        state_d  = DIV_FIX;
                        cnt_d    = '0;
                    end else if (a1 < a2) begin
                        dp_d.quo = '0;
                        dp_d.rem = a1;
                        state_d  = DIV_FIX;
                        cnt_d    = '0;
                    end else if (a2 == XLEN'(1)) begin
                        dp_d.quo = a1;
                        dp_d.rem = '0;
                        state_d  = DIV_FIX;
                        cnt_d    = '0;
                    end
`endif
                end
            end
            DIV_CALC: begin
                if (pipe_flush) begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end else begin
                    dp_d.rem = rem_c[UNROLL];
                    dp_d.quo = quo_c[UNROLL];
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                cnt_d   = '0;
                if (!pipe_flush && dp_q.rd != 5'd0) begin
                    wb_en_d   = 1'b1;
                    wb_data_d = dp_q.rem_sel ? r_fix : q_fix;
                    wb_rd_d   = dp_q.rd;
                    wb_tag_d  = dp_q.tag;
                end
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dp_q      <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_tag_q  <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_q      <= dp_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_tag_q  <= wb_tag_d;
            wb_en_q   <= wb_en_d;
        end
    end

    assign exu_div_busy     = (state_q != DIV_IDLE);
    assign div_wb_data      = wb_data_q;
    assign div_wb_rd_addr   = wb_rd_q;
    assign div_wb_instr_tag = wb_tag_q;
    assign div_wb_rd_wr_en  = wb_en_q;

    // IDU1 must hold a divide while the unit is busy.
    a_no_accept_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(acc_req && !pipe_flush && state_q != DIV_IDLE)
    );

endmodule
